// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and helpers for the instruction fetch controller.
// Widths are fixed at 32 bits because the prefetch entry is a packed struct.
package instr_fetch_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StDrain,
        StHalt
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  fault;
    } fetch_entry_t;

    // Word aligned and inside [base, base+bytes); the subtraction keeps the top edge wrap-safe.
    function automatic logic pc_is_legal(input logic [ADDR_WIDTH-1:0] pc,
                                         input logic [ADDR_WIDTH-1:0] base,
                                         input logic [ADDR_WIDTH-1:0] bytes);
        logic [ADDR_WIDTH-1:0] offset;
        offset = pc - base;
        return (pc[1:0] == 2'b00) && (pc >= base) && (offset < bytes);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle: redirect input, ROM read port and the decode valid/ready port.
// master = fetch controller, slave = surrounding core / ROM / decode.
interface instr_fetch_ctrl_if;
    import instr_fetch_ctrl_pkg::*;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_fault;

    modport master (
        input  redirect, redirect_pc, mem_rvalid, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, instr_pc, instr_fault
    );

    modport slave (
        output redirect, redirect_pc, mem_rvalid, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, instr_fault
    );

endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// Prefetch FIFO of fetch entries; Depth must be a power of two so pointers wrap naturally.
// Flush and reset clear the pointers; a push into a full FIFO is taken only alongside a pop.
module instr_fetch_ctrl_fifo
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  fetch_entry_t    wdata,
    input  logic            pop,
    input  logic            flush,
    output fetch_entry_t    head,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Boot-ROM instruction fetch sequencer: one outstanding read, prefetch FIFO towards decode,
// redirect flush with stale-read drain, and fault entries for misaligned/out-of-window PCs.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 32'hBFC0_0000,
    parameter int unsigned           ROM_BYTES  = 4096,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input logic                clk_i,
    input logic                rst_i,
    instr_fetch_ctrl_if.master bus
);

    localparam int unsigned     CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0]   DepthC = (CntW + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RomBytesC = ADDR_WIDTH'(ROM_BYTES);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_req_q;
    logic                  inflight_q;

    fetch_entry_t          push_entry;
    fetch_entry_t          head;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [CntW-1:0]       count;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  pc_legal;
    logic                  next_pc_legal;
    logic [CntW:0]         occupancy;
    logic                  issue_now;
    logic                  issue_chain;

    assign pop           = !empty && bus.instr_ready;
    assign next_pc       = fetch_pc_q + 32'd4;
    assign pc_legal      = pc_is_legal(fetch_pc_q, ROM_BASE, RomBytesC);
    assign next_pc_legal = pc_is_legal(next_pc, ROM_BASE, RomBytesC);
    assign occupancy     = {1'b0, count} + {{CntW{1'b0}}, inflight_q};

    always_comb begin
        push        = 1'b0;
        push_entry  = '0;
        issue_now   = 1'b0;
        issue_chain = 1'b0;
        if (!bus.redirect) begin
            unique case (state_q)
                StFetch: begin
                    if (pc_legal) begin
                        issue_now = (occupancy < DepthC);
                    end else if (!full) begin
                        push       = 1'b1;
                        push_entry = '{instr: NOP_INSTR, pc: fetch_pc_q, fault: 1'b1};
                    end
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        push       = 1'b1;
                        push_entry = '{instr: bus.mem_rdata, pc: fetch_pc_q, fault: 1'b0};
                        // Re-issue at once if the entry just pushed still leaves a free slot.
                        issue_chain = next_pc_legal &&
                                      (({1'b0, count} + 1'b1) < (DepthC + {{CntW{1'b0}}, pop}));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            if (bus.redirect) begin
                fetch_pc_q <= bus.redirect_pc;
                if (inflight_q && !bus.mem_rvalid) begin
                    state_q <= StDrain;
                end else begin
                    state_q    <= StFetch;
                    inflight_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StFetch;
                    StFetch: begin
                        if (issue_now) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= fetch_pc_q;
                            inflight_q <= 1'b1;
                            state_q    <= StWait;
                        end else if (push) begin
                            state_q <= StHalt;
                        end
                    end
                    StWait: begin
                        if (bus.mem_rvalid) begin
                            fetch_pc_q <= next_pc;
                            if (issue_chain) begin
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= next_pc;
                            end else begin
                                inflight_q <= 1'b0;
                                state_q    <= StFetch;
                            end
                        end
                    end
                    StDrain: begin
                        if (bus.mem_rvalid) begin
                            inflight_q <= 1'b0;
                            state_q    <= StFetch;
                        end
                    end
                    StHalt:  state_q <= StHalt;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    instr_fetch_ctrl_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .flush (bus.redirect),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = !empty;
    assign bus.instr       = empty ? '0 : head.instr;
    assign bus.instr_pc    = empty ? '0 : head.pc;
    assign bus.instr_fault = !empty && head.fault;

endmodule
